// File: rtl/tx_itrpt_cond_pkg.sv
// Shared types and default widths for the TX interrupt conditioner.
package tx_itrpt_cond_pkg;

  localparam int unsigned CntWDefault = 16;
  localparam int unsigned LenWDefault = 8;

  typedef enum logic [1:0] {
    StIdle,
    StAssert,
    StHoldoff
  } chan_state_e;

endpackage

// File: rtl/tx_itrpt_cond_chan.sv
// One interrupt channel: rising-edge detect, pulse/hold-off FSM with a one-deep
// deferred event, and a saturating event counter.
module tx_itrpt_cond_chan
  import tx_itrpt_cond_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault,
  parameter int unsigned LEN_W = LenWDefault
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tx_itrpt_in_i,
  input  logic             itrpt_en_i,
  input  logic [LEN_W-1:0] pulse_width_i,
  input  logic [LEN_W-1:0] holdoff_len_i,
  input  logic             event_cnt_clr_i,
  output logic             tx_itrpt_out_o,
  output logic [CNT_W-1:0] event_cnt_o,
  output logic             deferred_o
);

  chan_state_e      state_q, state_d;
  logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
  logic [CNT_W-1:0] ev_cnt_q, ev_cnt_d;
  logic             deferred_q, deferred_d;
  logic             out_q, out_d;
  logic             prev_q;

  logic             edge_ev;
  logic             defer_eff;
  logic [LEN_W-1:0] pw_load;
  logic [LEN_W-1:0] hl_load;

  assign edge_ev   = itrpt_en_i & tx_itrpt_in_i & ~prev_q;
  // An edge in the final cycle of a phase still queues a follow-on pulse.
  assign defer_eff = deferred_q | edge_ev;
  assign pw_load   = (pulse_width_i == '0) ? '0 : pulse_width_i - LEN_W'(1);
  assign hl_load   = holdoff_len_i - LEN_W'(1);

  always_comb begin
    state_d    = state_q;
    len_cnt_d  = len_cnt_q;
    deferred_d = deferred_q;
    if (!itrpt_en_i) begin
      state_d    = StIdle;
      len_cnt_d  = '0;
      deferred_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (edge_ev) begin
            state_d   = StAssert;
            len_cnt_d = pw_load;
          end
        end
        StAssert, StHoldoff: begin
          if (edge_ev) deferred_d = 1'b1;
          if (len_cnt_q != '0) begin
            len_cnt_d = len_cnt_q - LEN_W'(1);
          end else if (state_q == StAssert && holdoff_len_i != '0) begin
            state_d   = StHoldoff;
            len_cnt_d = hl_load;
          end else if (defer_eff) begin
            state_d    = StAssert;
            len_cnt_d  = pw_load;
            deferred_d = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    out_d = (state_d == StAssert);
    ev_cnt_d = ev_cnt_q;
    if (event_cnt_clr_i) begin
      ev_cnt_d = '0;
    end else if (edge_ev && (ev_cnt_q != '1)) begin
      ev_cnt_d = ev_cnt_q + CNT_W'(1);
    end
  end

  // prev resets high so a source already asserted at reset release is ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      len_cnt_q  <= '0;
      ev_cnt_q   <= '0;
      deferred_q <= 1'b0;
      out_q      <= 1'b0;
      prev_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      len_cnt_q  <= len_cnt_d;
      ev_cnt_q   <= ev_cnt_d;
      deferred_q <= deferred_d;
      out_q      <= out_d;
      prev_q     <= tx_itrpt_in_i;
    end
  end

  assign tx_itrpt_out_o = out_q;
  assign event_cnt_o    = ev_cnt_q;
  assign deferred_o     = deferred_q;

endmodule

// File: rtl/tx_itrpt_conditioner.sv
// Conditions the two TX interrupt lines into clean, spaced pulses for the PS
// interrupt controller; the two channels share the width/hold-off registers.
module tx_itrpt_conditioner
  import tx_itrpt_cond_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault,
  parameter int unsigned LEN_W = LenWDefault
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       tx_itrpt_in,
  input  logic [1:0]       itrpt_en,
  input  logic [LEN_W-1:0] pulse_width,
  input  logic [LEN_W-1:0] holdoff_len,
  input  logic [1:0]       event_cnt_clr,
  output logic [1:0]       tx_itrpt_out,
  output logic [CNT_W-1:0] event_cnt0,
  output logic [CNT_W-1:0] event_cnt1,
  output logic [1:0]       deferred
);

  tx_itrpt_cond_chan #(
    .CNT_W(CNT_W),
    .LEN_W(LEN_W)
  ) u_chan0 (
    .clk_i          (clk),
    .rst_ni         (rstn),
    .tx_itrpt_in_i  (tx_itrpt_in[0]),
    .itrpt_en_i     (itrpt_en[0]),
    .pulse_width_i  (pulse_width),
    .holdoff_len_i  (holdoff_len),
    .event_cnt_clr_i(event_cnt_clr[0]),
    .tx_itrpt_out_o (tx_itrpt_out[0]),
    .event_cnt_o    (event_cnt0),
    .deferred_o     (deferred[0])
  );

  tx_itrpt_cond_chan #(
    .CNT_W(CNT_W),
    .LEN_W(LEN_W)
  ) u_chan1 (
    .clk_i          (clk),
    .rst_ni         (rstn),
    .tx_itrpt_in_i  (tx_itrpt_in[1]),
    .itrpt_en_i     (itrpt_en[1]),
    .pulse_width_i  (pulse_width),
    .holdoff_len_i  (holdoff_len),
    .event_cnt_clr_i(event_cnt_clr[1]),
    .tx_itrpt_out_o (tx_itrpt_out[1]),
    .event_cnt_o    (event_cnt1),
    .deferred_o     (deferred[1])
  );

endmodule

// File: tb/tb_tx_itrpt_conditioner.sv
// Directed bench for tx_itrpt_conditioner: a remaining-cycles model checked every
// cycle, plus literal expectations for the key waveforms.
module tb_tx_itrpt_conditioner;

  localparam int CW   = 8;
  localparam int LW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk  = 1'b0;
  logic          rstn = 1'b1;
  logic [1:0]    tx_in = 2'b00;
  logic [1:0]    en    = 2'b00;
  logic [1:0]    clr   = 2'b00;
  logic [LW-1:0] pw    = '0;
  logic [LW-1:0] hl    = '0;
  logic [1:0]    out;
  logic [1:0]    dfr;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  tx_itrpt_conditioner #(
    .CNT_W(CW),
    .LEN_W(LW)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .tx_itrpt_in  (tx_in),
    .itrpt_en     (en),
    .pulse_width  (pw),
    .holdoff_len  (hl),
    .event_cnt_clr(clr),
    .tx_itrpt_out (out),
    .event_cnt0   (cnt0),
    .event_cnt1   (cnt1),
    .deferred     (dfr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: cycles of high / low time still owed, one pending event, counter.
  typedef struct packed {
    int hi;
    int lo;
    bit pend;
    bit prev;
    int cnt;
  } mst_t;

  function automatic mst_t m_reset();
    mst_t s;
    s.hi = 0; s.lo = 0; s.pend = 1'b0; s.prev = 1'b1; s.cnt = 0;
    return s;
  endfunction

  function automatic mst_t step(mst_t s, bit in, bit en_b, bit clr_b, int pwe, int hlen);
    mst_t n;
    bit ev;
    n = s;
    ev = en_b && in && !s.prev;
    n.prev = in;
    if (clr_b) n.cnt = 0;
    else if (ev && s.cnt < MAXC) n.cnt = s.cnt + 1;
    if (!en_b) begin
      n.hi = 0; n.lo = 0; n.pend = 1'b0;
    end else if (s.hi > 0) begin
      n.pend = s.pend | ev;
      n.hi = s.hi - 1;
      if (n.hi == 0) begin
        if (hlen > 0) n.lo = hlen;
        else if (n.pend) begin n.hi = pwe; n.pend = 1'b0; end
      end
    end else if (s.lo > 0) begin
      n.pend = s.pend | ev;
      n.lo = s.lo - 1;
      if (n.lo == 0 && n.pend) begin n.hi = pwe; n.pend = 1'b0; end
    end else if (ev) begin
      n.hi = pwe;
    end
    return n;
  endfunction

  mst_t m0 = m_reset();
  mst_t m1 = m_reset();

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m0 <= m_reset();
      m1 <= m_reset();
    end else begin
      m0 <= step(m0, tx_in[0], en[0], clr[0], (pw == 0) ? 1 : int'(pw), int'(hl));
      m1 <= step(m1, tx_in[1], en[1], clr[1], (pw == 0) ? 1 : int'(pw), int'(hl));
    end
  end

  always @(negedge clk) begin
    chk("model out0", 32'(out[0]), 32'(m0.hi > 0));
    chk("model out1", 32'(out[1]), 32'(m1.hi > 0));
    chk("model deferred0", 32'(dfr[0]), 32'(m0.pend));
    chk("model deferred1", 32'(dfr[1]), 32'(m1.pend));
    chk("model cnt0", 32'(cnt0), 32'(m0.cnt));
    chk("model cnt1", 32'(cnt1), 32'(m1.cnt));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Source 0 already high through reset release: no event.
    pw = 8'd4; hl = 8'd0; en = 2'b11; tx_in = 2'b01;
    #1 rstn = 1'b0;
    tick(2);
    #2 rstn = 1'b1;
    tick(3);
    chk("held level out0", 32'(out[0]), 32'd0);
    chk("held level cnt0", 32'(cnt0), 32'd0);
    tx_in[0] = 1'b0; tick(1);
    tx_in[0] = 1'b1; tick(1);
    tx_in[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("pw4 high", 32'(out[0]), 32'd1);
      tick(1);
    end
    chk("pw4 end low", 32'(out[0]), 32'd0);
    chk("pw4 cnt0", 32'(cnt0), 32'd1);

    // Deferred pulse behind a 5-cycle hold-off.
    pw = 8'd3; hl = 8'd5;
    tx_in[0] = 1'b1; tick(1);
    tx_in[0] = 1'b0; chk("b2b first a", 32'(out[0]), 32'd1); tick(1);
    tx_in[0] = 1'b1; chk("b2b first b", 32'(out[0]), 32'd1); tick(1);
    tx_in[0] = 1'b0; chk("b2b first c", 32'(out[0]), 32'd1);
    chk("b2b deferred set", 32'(dfr[0]), 32'd1);
    tick(1);
    for (int i = 0; i < 5; i++) begin
      chk("b2b holdoff low", 32'(out[0]), 32'd0);
      tick(1);
    end
    for (int i = 0; i < 3; i++) begin
      chk("b2b second high", 32'(out[0]), 32'd1);
      tick(1);
    end
    chk("b2b end low", 32'(out[0]), 32'd0);
    chk("b2b cnt0", 32'(cnt0), 32'd3);
    tick(8);

    // Width 0 acts as 1; zero hold-off chains pulses back to back.
    pw = 8'd0; hl = 8'd0;
    tx_in[0] = 1'b1; tick(1);
    tx_in[0] = 1'b0; chk("pw0 high", 32'(out[0]), 32'd1); tick(1);
    chk("pw0 low after 1", 32'(out[0]), 32'd0);
    pw = 8'd2;
    tx_in[0] = 1'b1; tick(1);
    tx_in[0] = 1'b0; chk("chain 1", 32'(out[0]), 32'd1); tick(1);
    tx_in[0] = 1'b1; chk("chain 2", 32'(out[0]), 32'd1); tick(1);
    tx_in[0] = 1'b0; chk("chain 3", 32'(out[0]), 32'd1); tick(1);
    chk("chain 4", 32'(out[0]), 32'd1); tick(1);
    chk("chain end", 32'(out[0]), 32'd0);
    tick(2);

    // Counter saturation and clear-wins.
    pw = 8'd1; hl = 8'd0;
    clr[0] = 1'b1; tick(1); clr[0] = 1'b0;
    chk("clr cnt0", 32'(cnt0), 32'd0);
    for (int i = 0; i < MAXC - 1; i++) begin
      tx_in[0] = 1'b1; tick(1); tx_in[0] = 1'b0; tick(1);
    end
    chk("preload cnt0", 32'(cnt0), 32'(MAXC - 1));
    for (int i = 0; i < 3; i++) begin
      tx_in[0] = 1'b1; tick(1); tx_in[0] = 1'b0; tick(1);
    end
    chk("saturate cnt0", 32'(cnt0), 32'(MAXC));
    tx_in[0] = 1'b1; clr[0] = 1'b1; tick(1);
    tx_in[0] = 1'b0; clr[0] = 1'b0;
    chk("clr wins cnt0", 32'(cnt0), 32'd0);
    tick(1);
    tx_in[0] = 1'b1; tick(1); tx_in[0] = 1'b0;
    chk("after clr cnt0", 32'(cnt0), 32'd1);
    tick(3);

    // Disable channel 0 mid-pulse with an event deferred; channel 1 keeps going.
    pw = 8'd4; hl = 8'd3;
    tx_in = 2'b11; tick(1);
    tx_in = 2'b00; tick(1);
    tx_in = 2'b01; tick(1);
    tx_in = 2'b00;
    chk("dis pre out0", 32'(out[0]), 32'd1);
    chk("dis pre deferred0", 32'(dfr[0]), 32'd1);
    en[0] = 1'b0; tick(1);
    chk("dis out0", 32'(out[0]), 32'd0);
    chk("dis deferred0", 32'(dfr[0]), 32'd0);
    chk("dis ch1 out1", 32'(out[1]), 32'd1);
    tx_in[0] = 1'b1; tick(1); tx_in[0] = 1'b0; tick(1);
    chk("dis edge cnt0", 32'(cnt0), 32'd3);
    chk("dis edge out0", 32'(out[0]), 32'd0);
    chk("ch1 cnt1", 32'(cnt1), 32'd1);
    en[0] = 1'b1;
    tick(12);

    // Asynchronous reset while ch0 is in hold-off and ch1 is mid-pulse.
    pw = 8'd2; hl = 8'd6;
    tx_in[0] = 1'b1; tick(1);
    tx_in[0] = 1'b0; chk("rst pre high", 32'(out[0]), 32'd1); tick(1);
    tx_in[1] = 1'b1; tick(1);
    tx_in[1] = 1'b0;
    chk("rst pre holdoff", 32'(out[0]), 32'd0);
    chk("rst pre ch1", 32'(out[1]), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("rst out", 32'(out), 32'd0);
    chk("rst deferred", 32'(dfr), 32'd0);
    chk("rst cnt0", 32'(cnt0), 32'd0);
    chk("rst cnt1", 32'(cnt1), 32'd0);
    tick(1);
    #2 rstn = 1'b1;
    tick(1);
    tx_in[0] = 1'b1; tick(1);
    tx_in[0] = 1'b0; chk("post rst high a", 32'(out[0]), 32'd1); tick(1);
    chk("post rst high b", 32'(out[0]), 32'd1); tick(1);
    chk("post rst low", 32'(out[0]), 32'd0);
    chk("post rst cnt0", 32'(cnt0), 32'd1);
    tick(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
